// File: rtl/ifu.sv
// Instruction fetch unit: single-outstanding imem requests feeding a {pc, inst} buffer for decode.
// Optional IFU_PERF_EN adds fetch/stall performance counters.
//
// state | meaning
// IDLE  | buffer full, waiting for a free slot
// REQ   | request presented on imem, waiting for ready
// WAIT  | request accepted, waiting for its response
// DROP  | accepted request went stale after a redirect, swallow its response
module ifu #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
`ifdef IFU_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc, fetch_pc_nxt, pend_pc;
  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic [31:0]   fifo_inst [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          req_hs, push, pop;

  assign imem_req_valid = (state == S_REQ);
  assign imem_req_addr  = fetch_pc;
  assign inst_valid     = (count != '0);
  assign inst           = fifo_inst[rd_ptr];
  assign inst_pc        = fifo_pc[rd_ptr];

  assign req_hs = (state == S_REQ) && imem_req_ready;
  assign pop    = inst_valid && inst_ready;
  // A response racing a redirect belongs to the old stream and is never buffered.
  assign push   = (state == S_WAIT) && imem_rsp_valid && !redirect_valid;

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + CW'(1);
    else if (!push && pop)
      count_nxt = count - CW'(1);
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    case (state)
      S_IDLE: if (count < DEPTH_C) state_nxt = S_REQ;
      S_REQ: begin
        if (imem_req_ready) begin
          state_nxt    = S_WAIT;
          fetch_pc_nxt = fetch_pc + 32'd4;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid)
          state_nxt = (count_nxt < DEPTH_C) ? S_REQ : S_IDLE;
      end
      S_DROP: if (imem_rsp_valid) state_nxt = S_REQ;
      default: state_nxt = S_IDLE;
    endcase
    if (redirect_valid) begin
      fetch_pc_nxt = redirect_pc & ~32'h3;
      case (state)
        S_REQ:   state_nxt = req_hs ? S_DROP : S_REQ;
        S_WAIT:  state_nxt = imem_rsp_valid ? S_REQ : S_DROP;
        S_DROP:  state_nxt = S_DROP;
        default: state_nxt = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      pend_pc  <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      if (req_hs)
        pend_pc <= fetch_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc[i]   <= '0;
        fifo_inst[i] <= '0;
      end
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_pc[wr_ptr]   <= pend_pc;
        fifo_inst[wr_ptr] <= imem_rsp_data;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
    end
  end

`ifdef IFU_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (push)
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (!inst_valid)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
